// File: rtl/mips_alu_exec_unit.sv
// EX-stage execution unit: ALU-control decode, registered ALU and iterative HI/LO multiplier.
// Define MIPS_ALU_DIV_EN to add the iterative div/divu path (state DIV).
module mips_alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               valid_in,
    input  logic [1:0]         aluopex,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               flush,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               valid_out,
    output logic [3:0]         aluct,
    output logic               stall,
    output logic               illegal
);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] ONE_C  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_START = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     result_r, hi_r, lo_r, mcand_r;
    logic                 zero_r, valid_out_r, stall_r, illegal_r, neg_q_r;
    logic [3:0]           aluct_r;
    logic [SHAMT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0]   prod_r;

    logic [3:0]           aluct_s;
    logic                 illegal_s, is_mul_s, is_div_s, signed_op_s;
    logic                 wr_hi_s, wr_lo_s, produces_s, accept_s, neg_s;
    logic [WIDTH-1:0]     result_s, abs_a_s, abs_b_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s, mul_full_s;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        neg_if = en ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic en);
        neg2_if = en ? (~v + ONE_2W) : v;
    endfunction

    assign accept_s = valid_in && !flush && (state_r == IDLE);

    // ALU-control decode from ALUOP and funct
    always_comb begin
        aluct_s     = 4'b0000;
        illegal_s   = 1'b0;
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        signed_op_s = 1'b0;
        wr_hi_s     = 1'b0;
        wr_lo_s     = 1'b0;
        produces_s  = 1'b1;
        case (aluopex)
            2'b00: aluct_s = 4'b0010;
            2'b01: aluct_s = 4'b0110;
            2'b11: aluct_s = 4'b1110;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: aluct_s = 4'b0010;
                    6'b100010, 6'b100011: aluct_s = 4'b0110;
                    6'b100100: aluct_s = 4'b0000;
                    6'b100101: aluct_s = 4'b0001;
                    6'b100111: aluct_s = 4'b1100;
                    6'b100110: aluct_s = 4'b1101;
                    6'b101010: aluct_s = 4'b0111;
                    6'b101011: aluct_s = 4'b1000;
                    6'b000000: aluct_s = 4'b0011;
                    6'b000010: aluct_s = 4'b0100;
                    6'b000011: aluct_s = 4'b0101;
                    6'b010000: aluct_s = 4'b1001;
                    6'b010010: aluct_s = 4'b1010;
                    6'b010001: begin aluct_s = 4'b1011; wr_hi_s = 1'b1; produces_s = 1'b0; end
                    6'b010011: begin aluct_s = 4'b1011; wr_lo_s = 1'b1; produces_s = 1'b0; end
                    6'b011000: begin aluct_s = 4'b1111; is_mul_s = 1'b1; signed_op_s = 1'b1; produces_s = 1'b0; end
                    6'b011001: begin aluct_s = 4'b1111; is_mul_s = 1'b1; produces_s = 1'b0; end
`ifdef MIPS_ALU_DIV_EN
                    6'b011010: begin aluct_s = 4'b1111; is_div_s = 1'b1; signed_op_s = 1'b1; produces_s = 1'b0; end
                    6'b011011: begin aluct_s = 4'b1111; is_div_s = 1'b1; produces_s = 1'b0; end
`endif
                    default: begin illegal_s = 1'b1; produces_s = 1'b0; end
                endcase
            end
            default: begin illegal_s = 1'b1; produces_s = 1'b0; end
        endcase
    end

    // Single-cycle ALU result selected by the decoded control code
    always_comb begin
        result_s = {WIDTH{1'b0}};
        if (illegal_s) begin
            result_s = {WIDTH{1'b0}};
        end else begin
            case (aluct_s)
                4'b0010: result_s = srca + srcb;
                4'b0110: result_s = srca - srcb;
                4'b0000: result_s = srca & srcb;
                4'b0001: result_s = srca | srcb;
                4'b1100: result_s = ~(srca | srcb);
                4'b1101: result_s = srca ^ srcb;
                4'b0111: result_s = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
                4'b1000: result_s = {{(WIDTH-1){1'b0}}, (srca < srcb)};
                4'b0011: result_s = srcb << shamt;
                4'b0100: result_s = srcb >> shamt;
                4'b0101: result_s = $signed(srcb) >>> shamt;
                4'b1001: result_s = hi_r;
                4'b1010: result_s = lo_r;
                4'b1110: result_s = {srcb[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                default: result_s = {WIDTH{1'b0}};
            endcase
        end
    end

    // Operand magnitudes and one shift-add multiply step on {upper, multiplier}
    always_comb begin
        abs_a_s    = neg_if(srca, signed_op_s & srca[WIDTH-1]);
        abs_b_s    = neg_if(srcb, signed_op_s & srcb[WIDTH-1]);
        neg_s      = signed_op_s & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
        mul_full_s = neg2_if(mul_next_s, neg_q_r);
    end

`ifdef MIPS_ALU_DIV_EN
    logic               neg_r_r;
    logic [WIDTH:0]     div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] div_next_s;

    // One restoring-division step on {remainder, quotient}
    always_comb begin
        div_shift_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_r};
        if (!div_diff_s[WIDTH]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // Control FSM, HI/LO registers and all registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            valid_out_r <= 1'b0;
            aluct_r     <= 4'b0000;
            stall_r     <= 1'b0;
            illegal_r   <= 1'b0;
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
            prod_r      <= {(2*WIDTH){1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            neg_q_r     <= 1'b0;
`ifdef MIPS_ALU_DIV_EN
            neg_r_r     <= 1'b0;
`endif
        end else begin
            valid_out_r <= 1'b0;
            illegal_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        aluct_r     <= aluct_s;
                        result_r    <= result_s;
                        zero_r      <= (result_s == {WIDTH{1'b0}});
                        valid_out_r <= produces_s;
                        illegal_r   <= illegal_s;
                        if (wr_hi_s) begin
                            hi_r <= srca;
                        end else if (wr_lo_s) begin
                            lo_r <= srca;
                        end else if (is_mul_s) begin
                            state_r <= MUL;
                            stall_r <= 1'b1;
                            cnt_r   <= CNT_START;
                            mcand_r <= abs_a_s;
                            prod_r  <= {{WIDTH{1'b0}}, abs_b_s};
                            neg_q_r <= neg_s;
                        end else if (is_div_s) begin
`ifdef MIPS_ALU_DIV_EN
                            // Divide by zero completes immediately without stalling
                            if (srcb == {WIDTH{1'b0}}) begin
                                hi_r <= srca;
                                lo_r <= {WIDTH{1'b1}};
                            end else begin
                                state_r <= DIV;
                                stall_r <= 1'b1;
                                cnt_r   <= CNT_START;
                                mcand_r <= abs_b_s;
                                prod_r  <= {{WIDTH{1'b0}}, abs_a_s};
                                neg_q_r <= neg_s;
                                neg_r_r <= signed_op_s & srca[WIDTH-1];
                            end
`else
                            state_r <= IDLE;
`endif
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    if (flush) begin
                        state_r <= IDLE;
                        stall_r <= 1'b0;
                    end else if (cnt_r == {SHAMT_W{1'b0}}) begin
                        hi_r    <= mul_full_s[2*WIDTH-1:WIDTH];
                        lo_r    <= mul_full_s[WIDTH-1:0];
                        state_r <= IDLE;
                        stall_r <= 1'b0;
                    end else begin
                        prod_r <= mul_next_s;
                        cnt_r  <= cnt_r - ONE_C;
                    end
                end
`ifdef MIPS_ALU_DIV_EN
                DIV: begin
                    if (flush) begin
                        state_r <= IDLE;
                        stall_r <= 1'b0;
                    end else if (cnt_r == {SHAMT_W{1'b0}}) begin
                        lo_r    <= neg_if(div_next_s[WIDTH-1:0], neg_q_r);
                        hi_r    <= neg_if(div_next_s[2*WIDTH-1:WIDTH], neg_r_r);
                        state_r <= IDLE;
                        stall_r <= 1'b0;
                    end else begin
                        prod_r <= div_next_s;
                        cnt_r  <= cnt_r - ONE_C;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    stall_r <= 1'b0;
                end
            endcase
        end
    end

    assign result    = result_r;
    assign zero      = zero_r;
    assign valid_out = valid_out_r;
    assign aluct     = aluct_r;
    assign stall     = stall_r;
    assign illegal   = illegal_r;
endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Directed bench for mips_alu_exec_unit: scoreboard of expected results checked on VALID_OUT.
module tb_mips_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rstn, valid_in, flush;
    logic [1:0]  aluopex;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] srca, srcb;
    logic [31:0] result;
    logic        zero, valid_out, stall, illegal;
    logic [3:0]  aluct;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ct;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    mips_alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .aluopex(aluopex), .funct(funct),
        .shamt(shamt), .srca(srca), .srcb(srcb), .flush(flush), .result(result),
        .zero(zero), .valid_out(valid_out), .aluct(aluct), .stall(stall), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every VALID_OUT pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid_out", 32'(valid_out), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", result, e.res);
                check("sb_zero", 32'(zero), 32'(e.res == 32'd0));
                check("sb_aluct", 32'(aluct), 32'(e.ct));
            end
        end
    end

    task automatic op(input logic [1:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input logic push,
                      input logic [31:0] eres, input logic [3:0] ect);
        valid_in = 1'b1;
        aluopex  = aop;
        funct    = fn;
        shamt    = sh;
        srca     = a;
        srcb     = b;
        if (push) sb_q.push_back('{eres, ect});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a, b;
        rstn = 1'b0; valid_in = 1'b0; flush = 1'b0; aluopex = 2'd0; funct = 6'd0;
        shamt = 5'd0; srca = 32'd0; srcb = 32'd0;
        #3;
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_aluct", 32'(aluct), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        #9 rstn = 1'b1;
        @(posedge clk); #1;

        // back-to-back single-cycle ops
        a = 32'hF0F0_1234; b = 32'h0FF0_5678;
        op(2'd2, 6'b100000, 5'd0, 32'd5, 32'd7, 1'b1, 32'd12, 4'b0010);
        op(2'd2, 6'b100010, 5'd0, 32'd9, 32'd9, 1'b1, 32'd0, 4'b0110);
        op(2'd2, 6'b000011, 5'd4, 32'd0, 32'h8000_0000, 1'b1, 32'hF800_0000, 4'b0101);
        op(2'd2, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 4'b1000);
        op(2'd2, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 4'b0111);
        op(2'd2, 6'b100100, 5'd0, a, b, 1'b1, a & b, 4'b0000);
        op(2'd2, 6'b100101, 5'd0, a, b, 1'b1, a | b, 4'b0001);
        op(2'd2, 6'b100111, 5'd0, a, b, 1'b1, ~(a | b), 4'b1100);
        op(2'd2, 6'b100110, 5'd0, a, b, 1'b1, a ^ b, 4'b1101);
        op(2'd2, 6'b000000, 5'd31, 32'd0, 32'd1, 1'b1, 32'h8000_0000, 4'b0011);
        op(2'd2, 6'b000010, 5'd31, 32'd0, 32'h8000_0000, 1'b1, 32'd1, 4'b0100);
        op(2'd3, 6'b000000, 5'd0, 32'd0, 32'h5555_ABCD, 1'b1, 32'hABCD_0000, 4'b1110);
        op(2'd0, 6'b111111, 5'd0, 32'd100, 32'd20, 1'b1, 32'd120, 4'b0010);
        op(2'd1, 6'b111111, 5'd0, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b0110);
        op(2'd2, 6'b100001, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 4'b0010);

        // illegal funct
        op(2'd2, 6'b111111, 5'd0, 32'd1, 32'd2, 1'b0, 32'd0, 4'b0000);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_valid", 32'(valid_out), 32'd0);
        check("ill_result", result, 32'd0);
        idle();
        check("ill_one_cycle", 32'(illegal), 32'd0);

        // flush in IDLE suppresses accept
        flush = 1'b1;
        op(2'd2, 6'b100000, 5'd0, 32'd1, 32'd1, 1'b0, 32'd0, 4'b0000);
        check("flush_idle_valid", 32'(valid_out), 32'd0);
        flush = 1'b0;

        // signed multiply; an ADD held during stall must be ignored
        op(2'd2, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0, 4'b0000);
        check("mult_valid", 32'(valid_out), 32'd0);
        funct = 6'b100000; srca = 32'd1; srcb = 32'd1;
        wait_stall(n);
        check("mult_stall_len", 32'(n), 32'd32);
        op(2'd2, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 4'b1001);
        op(2'd2, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFEB, 4'b1010);

        // unsigned multiply
        op(2'd2, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 4'b0000);
        valid_in = 1'b0;
        wait_stall(n);
        check("multu_stall_len", 32'(n), 32'd32);
        op(2'd2, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b1, 32'd1, 4'b1001);
        op(2'd2, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFE, 4'b1010);

        // MTLO, then multiply aborted by FLUSH on the 10th stall cycle
        op(2'd2, 6'b010011, 5'd0, 32'h0000_1234, 32'd0, 1'b0, 32'd0, 4'b0000);
        op(2'd2, 6'b011000, 5'd0, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0000);
        valid_in = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("pre_flush_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_mul_stall", 32'(stall), 32'd0);
        op(2'd2, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b1, 32'h0000_1234, 4'b1010);
        op(2'd2, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b1, 32'd1, 4'b1001);

        // reset in the middle of a multiply
        op(2'd2, 6'b011001, 5'd0, 32'd9, 32'd9, 1'b0, 32'd0, 4'b0000);
        valid_in = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        check("mrst_result", result, 32'd0);
        check("mrst_zero", 32'(zero), 32'd0);
        check("mrst_aluct", 32'(aluct), 32'd0);
        check("mrst_stall", 32'(stall), 32'd0);
        check("mrst_valid", 32'(valid_out), 32'd0);
        check("mrst_illegal", 32'(illegal), 32'd0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        op(2'd2, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, 4'b1001);
        op(2'd2, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, 4'b1010);

`ifdef MIPS_ALU_DIV_EN
        op(2'd2, 6'b011010, 5'd0, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd0, 4'b0000);
        valid_in = 1'b0;
        wait_stall(n);
        check("div_stall_len", 32'(n), 32'd32);
        op(2'd2, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF2, 4'b1010);
        op(2'd2, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b1, 32'd2, 4'b1001);
        op(2'd2, 6'b011011, 5'd0, 32'hCAFE_0001, 32'd0, 1'b0, 32'd0, 4'b0000);
        check("divz_stall", 32'(stall), 32'd0);
        op(2'd2, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 4'b1010);
        op(2'd2, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b1, 32'hCAFE_0001, 4'b1001);
`else
        op(2'd2, 6'b011010, 5'd0, 32'd100, 32'd7, 1'b0, 32'd0, 4'b0000);
        check("div_illegal", 32'(illegal), 32'd1);
        check("div_no_stall", 32'(stall), 32'd0);
`endif
        idle();
        idle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_alu_exec_unit.md
Name: mips_alu_exec_unit

Overview:
Parametrised EX-stage execution unit for the pipelined MIPS core. It combines ALU-control decode (ALUOP plus funct) with a registered WIDTH-bit ALU and an iterative HI/LO multiplier. It raises STALL while a multi-cycle operation runs, so the hazard unit freezes IF/ID/EX. It supersedes the combinational ALU-control plus ALU pair in the EX stage.

Parameters:
WIDTH, 32, operand/result width; even, >=8
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH)

Ports:
CLK  input  1  pipeline clock, rising edge
RSTN  input  1  asynchronous active-low reset
VALID_IN  input  1  valid instruction present in EX this cycle
ALUOPEX  input  2  ALUOP from control unit: 0 load/store add, 1 branch sub, 2 R-type, 3 LUI
FUNCT  input  6  instruction funct field
SHAMT  input  SHAMT_W  shift amount field
SRCA  input  WIDTH  operand A (rs, after forwarding)
SRCB  input  WIDTH  operand B (rt or immediate, after forwarding)
FLUSH  input  1  kill current EX instruction / abort multi-cycle op
RESULT  output  WIDTH  registered ALU result
ZERO  output  1  registered (RESULT == 0)
VALID_OUT  output  1  RESULT valid for EX/MEM, one-cycle pulse per instruction
ALUCT  output  4  registered decoded control code
STALL  output  1  multi-cycle op in progress; upstream holds inputs
ILLEGAL  output  1  one-cycle pulse: unsupported funct with ALUOPEX=2

Behaviour:
- Reset (RSTN low, async): RESULT=0, ZERO=0, VALID_OUT=0, ALUCT=0, STALL=0, ILLEGAL=0, HI=LO=0, FSM->IDLE. This applies immediately and also aborts an in-flight multiply.
- Accept: input accepted on a rising edge when VALID_IN=1, FLUSH=0, STALL=0. VALID_IN is ignored while STALL=1.
- Single-cycle ops: RESULT, ZERO, ALUCT and VALID_OUT are updated on the accept edge (latency 1). VALID_OUT is 0 on cycles with no accept.
- Decode: ALUOPEX 0 -> add 0010; 1 -> sub 0110; 3 -> LUI 1110, RESULT = SRCB[WIDTH/2-1:0] << WIDTH/2.
- ALUOPEX 2 funct map:
  - 100000/100001 add 0010; 100010/100011 sub 0110
  - 100100 and 0000; 100101 or 0001; 100111 nor 1100; 100110 xor 1101
  - 101010 slt 0111 (signed); 101011 sltu 1000
  - 000000 sll 0011; 000010 srl 0100; 000011 sra 0101 (shift SRCB by SHAMT)
  - 010000 mfhi 1001 (RESULT=HI); 010010 mflo 1010 (RESULT=LO)
  - 010001 mthi / 010011 mtlo 1011: write HI/LO from SRCA, VALID_OUT=0
  - 011000 mult / 011001 multu 1111: multi-cycle
  - Any other funct: ALUCT=0000, RESULT=0, VALID_OUT=0, ILLEGAL=1 for one cycle.
- Arithmetic: add/sub wrap modulo 2^WIDTH with no overflow trap; slt/sltu write 1 or 0 zero-extended.
- FSM states IDLE, MUL:
  - IDLE->MUL on accepted mult/multu; latch |A| and |B| (signed) or raw values (unsigned), plus sign flag.
  - MUL: radix-2 shift-add, one bit per cycle; counter runs WIDTH-1 down to 0.
  - At count 0: write the 2*WIDTH product (negated if sign flag set) to {HI,LO}; MUL->IDLE.
  - STALL=1 for exactly WIDTH cycles after the accept edge. Mult produces VALID_OUT=0.
- FLUSH:
  - In IDLE: suppresses accept that cycle (no VALID_OUT, no HI/LO write).
  - In MUL: abort; next state IDLE, STALL=0 next cycle, HI/LO retain prior values.
- MFHI/MFLO accepted the cycle STALL falls reads the new HI/LO.
- Back-to-back single-cycle ops: one per cycle, no bubbles.

Optional Feature:
Macro MIPS_ALU_DIV_EN.
- Defined:
  - funct 011010 div / 011011 divu (ALUCT 1111) use state DIV: restoring division, WIDTH cycles, same STALL/FLUSH rules as MUL.
  - Results: LO=quotient, HI=remainder. Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - SRCB=0: no iteration, STALL stays 0, HI=SRCA, LO=all ones, written on the accept edge.
- Undefined: div/divu decode as illegal (ILLEGAL pulse, no state change).

Test Plan:
- ALUOPEX=2, FUNCT=100000, SRCA=5, SRCB=7 -> next edge RESULT=12, ZERO=0, VALID_OUT=1, ALUCT=0010; then SUB 9-9 -> RESULT=0, ZERO=1.
- SRA: SRCB=0x80000000, SHAMT=4 -> RESULT=0xF8000000; SLTU with SRCA=0xFFFFFFFF, SRCB=1 -> RESULT=0; SLT with the same operands -> RESULT=1.
- MULT SRCA=-3, SRCB=7 -> STALL high 32 cycles, VALID_OUT=0; then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFEB. MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- MTLO 0x1234, then MULT started with FLUSH at the 10th stall cycle -> STALL low next cycle; MFLO -> 0x1234. Repeat with RSTN low mid-multiply -> all outputs 0, HI=LO=0.
- FUNCT=111111 with ALUOPEX=2 -> ILLEGAL one-cycle pulse, VALID_OUT=0, RESULT=0; VALID_IN=1 during STALL -> ignored.
- With MIPS_ALU_DIV_EN: DIV 100/-7 -> LO=-14, HI=2 after 32 stall cycles. DIVU x/0 -> STALL stays 0, LO=0xFFFFFFFF, HI=x. Without the macro: DIV -> ILLEGAL.
